// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer.
// Fetches a two-byte instruction over a byte-wide memory port: the low byte
// comes from pc and the high byte from pc+1. The assembled word is held for
// decode, and pc_en pulses when decode takes it.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | halted, no fetch in flight
// REQ0  | requesting low byte at pc
// WAIT0 | low byte accepted, waiting for read data
// REQ1  | requesting high byte at pc+1 (wraps at the address width)
// WAIT1 | high byte accepted, waiting for read data
// HOLD  | instruction complete, presented to decode until accepted

module fetch_sequencer #(
    parameter int I_ADDR_W = 12,
    parameter int DATA_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [I_ADDR_W-1:0]   pc,
    input  logic                  halt,
    output logic                  imem_req,
    output logic [I_ADDR_W-1:0]   imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [DATA_W-1:0]     imem_rdata,
    output logic [2*DATA_W-1:0]   inst,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic                  pc_en,
    output logic                  busy,
    output logic                  protocol_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       accepted;
    logic       taken;
    logic       rvalid_expected;

    assign accepted        = imem_req && imem_ready;
    assign taken           = (state == S_HOLD) && inst_ready;
    assign rvalid_expected = (state == S_WAIT0) || (state == S_WAIT1);

    // Next-state selection; halt only gates the start of a new fetch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!halt) state_nxt = S_REQ0;
            S_REQ0:  if (accepted) state_nxt = S_WAIT0;
            S_WAIT0: if (imem_rvalid) state_nxt = S_REQ1;
            S_REQ1:  if (accepted) state_nxt = S_WAIT1;
            S_WAIT1: if (imem_rvalid) state_nxt = S_HOLD;
            S_HOLD:  if (inst_ready) state_nxt = halt ? S_IDLE : S_REQ0;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Byte capture into the instruction word; reset drops any partial bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst <= '0;
        end else if (imem_rvalid && (state == S_WAIT0)) begin
            inst[DATA_W-1:0] <= imem_rdata;
        end else if (imem_rvalid && (state == S_WAIT1)) begin
            inst[2*DATA_W-1:DATA_W] <= imem_rdata;
        end
    end

    // Sticky flag for read data arriving when no read is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            protocol_err <= 1'b0;
        end else if (imem_rvalid && !rvalid_expected) begin
            protocol_err <= 1'b1;
        end
    end

    // Request address follows pc directly; pc only moves on pc_en, so it is
    // stable for the whole fetch and the address holds through a stall.
    always_comb begin
        imem_addr = '0;
        case (state)
            S_REQ0:  imem_addr = pc;
            S_REQ1:  imem_addr = pc + {{(I_ADDR_W-1){1'b0}}, 1'b1};
            default: imem_addr = '0;
        endcase
    end

    assign imem_req   = (state == S_REQ0) || (state == S_REQ1);
    assign inst_valid = (state == S_HOLD);
    assign pc_en      = taken;
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table of instruction fetches run
// back-to-back, then hand-written sequences for stalls, halt, stray read
// data and mid-fetch reset.

module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic [11:0] pc;
    logic        halt;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [7:0]  imem_rdata;
    logic [15:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        pc_en;
    logic        busy;
    logic        protocol_err;

    fetch_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .halt         (halt),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .pc_en        (pc_en),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    typedef struct {
        logic [11:0] pc;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [11:0] a1;
        logic [15:0] inst;
    } vec_t;

    vec_t        vecs [4];
    logic [7:0]  mem [4096];
    int          n_vec;
    int          n_err;
    logic        force_rv;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: read data one cycle after acceptance; force_rv injects
    // a stray rvalid.
    initial begin
        logic        acc;
        logic [11:0] acc_addr;
        imem_rvalid = 1'b0;
        imem_rdata  = 8'h00;
        forever begin
            @(posedge clk);
            acc      = imem_req && imem_ready;
            acc_addr = imem_addr;
            @(negedge clk);
            imem_rvalid = acc || force_rv;
            imem_rdata  = acc ? mem[acc_addr] : 8'hEE;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Run until inst_valid (bounded), recording accepted request addresses.
    task automatic run_fetch(input int start, output int cyc, output logic [11:0] a0,
                             output logic [11:0] a1, output int nacc);
        cyc  = start;
        nacc = 0;
        a0   = '0;
        a1   = '0;
        while (!inst_valid && cyc < start + 20) begin
            if (imem_req && imem_ready) begin
                if (nacc == 0) a0 = imem_addr;
                else           a1 = imem_addr;
                nacc++;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          cyc;
        int          nacc;
        logic [11:0] a0;
        logic [11:0] a1;
        logic [15:0] held;

        n_vec    = 0;
        n_err    = 0;
        force_rv = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        vecs[0] = '{pc: 12'h010, b0: 8'h34, b1: 8'h12, a1: 12'h011, inst: 16'h1234};
        vecs[1] = '{pc: 12'hFFF, b0: 8'hCD, b1: 8'hAB, a1: 12'h000, inst: 16'hABCD};
        vecs[2] = '{pc: 12'h7FE, b0: 8'h00, b1: 8'hFF, a1: 12'h7FF, inst: 16'hFF00};
        vecs[3] = '{pc: 12'h123, b0: 8'h5A, b1: 8'hA5, a1: 12'h124, inst: 16'hA55A};
        for (int i = 0; i < 4; i++) begin
            mem[vecs[i].pc] = vecs[i].b0;
            mem[vecs[i].a1] = vecs[i].b1;
        end
        mem[12'h200] = 8'h11; mem[12'h201] = 8'h22;
        mem[12'h300] = 8'h77; mem[12'h301] = 8'h66;

        rst_n      = 1'b0;
        pc         = 12'h000;
        halt       = 1'b1;
        imem_ready = 1'b1;
        inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_inst", inst, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_imem_req", imem_req, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_pc_en", pc_en, 0);
        check("rst_protocol_err", protocol_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("halted_idle_busy", busy, 0);

        // Table-driven back-to-back fetches.
        pc   = vecs[0].pc;
        halt = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 4; i++) begin
            run_fetch(cyc, cyc, a0, a1, nacc);
            check($sformatf("v%0d_latency", i), cyc, 5);
            check($sformatf("v%0d_nacc", i), nacc, 2);
            check($sformatf("v%0d_addr0", i), a0, vecs[i].pc);
            check($sformatf("v%0d_addr1", i), a1, vecs[i].a1);
            check($sformatf("v%0d_inst", i), inst, vecs[i].inst);
            held = inst;
            repeat (3) begin
                @(posedge clk);
                @(negedge clk);
                check($sformatf("v%0d_hold_inst", i), inst, held);
                check($sformatf("v%0d_hold_valid", i), inst_valid, 1);
                check($sformatf("v%0d_hold_pc_en", i), pc_en, 0);
            end
            inst_ready = 1'b1;
            if (i == 3) halt = 1'b1;
            #1;
            check($sformatf("v%0d_pc_en_pulse", i), pc_en, 1);
            @(posedge clk);
            #1;
            inst_ready = 1'b0;
            if (i < 3) pc = vecs[i+1].pc;
            @(negedge clk);
            check($sformatf("v%0d_after_pc_en", i), pc_en, 0);
            check($sformatf("v%0d_after_valid", i), inst_valid, 0);
            if (i < 3) begin
                check($sformatf("v%0d_next_req", i), imem_req, 1);
                check($sformatf("v%0d_next_addr", i), imem_addr, vecs[i+1].pc);
            end else begin
                check("last_idle_busy", busy, 0);
                check("last_idle_req", imem_req, 0);
            end
            cyc = 1;
        end

        // Memory not ready for two cycles in REQ0.
        pc         = 12'h200;
        imem_ready = 1'b0;
        halt       = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_req", imem_req, 1);
            check("stall_addr", imem_addr, 12'h200);
        end
        imem_ready = 1'b1;
        run_fetch(2, cyc, a0, a1, nacc);
        check("stall_latency", cyc, 6);
        check("stall_addr0", a0, 12'h200);
        check("stall_addr1", a1, 12'h201);
        check("stall_inst", inst, 16'h2211);
        inst_ready = 1'b1;
        @(posedge clk);
        #1;
        inst_ready = 1'b0;
        pc         = 12'h300;
        @(negedge clk);
        check("b2b_addr", imem_addr, 12'h300);

        // halt raised in WAIT0 does not abort the fetch.
        @(posedge clk);
        @(negedge clk);
        check("wait0_busy", busy, 1);
        halt = 1'b1;
        run_fetch(2, cyc, a0, a1, nacc);
        check("halt_mid_valid", inst_valid, 1);
        check("halt_mid_inst", inst, 16'h6677);
        check("halt_mid_addr1", a0, 12'h301);
        inst_ready = 1'b1;
        @(posedge clk);
        #1;
        inst_ready = 1'b0;
        @(negedge clk);
        check("halt_idle_busy", busy, 0);
        check("halt_idle_req", imem_req, 0);
        @(posedge clk);
        @(negedge clk);
        check("halt_idle2_req", imem_req, 0);

        // Stray rvalid in IDLE sets a sticky error.
        check("perr_before", protocol_err, 0);
        @(posedge clk);
        #1 force_rv = 1'b1;
        @(posedge clk);
        #1 force_rv = 1'b0;
        @(negedge clk);
        check("perr_set", protocol_err, 1);
        check("perr_idle_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("perr_sticky", protocol_err, 1);

        // Reset in WAIT1 clears everything at once.
        pc   = 12'h010;
        halt = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_inst", inst, 0);
        check("mid_rst_valid", inst_valid, 0);
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_addr", imem_addr, 0);
        check("mid_rst_pc_en", pc_en, 0);
        check("mid_rst_perr", protocol_err, 0);
        pc = 12'h123;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_fetch(0, cyc, a0, a1, nacc);
        check("post_rst_latency", cyc, 5);
        check("post_rst_addr0", a0, 12'h123);
        check("post_rst_inst", inst, 16'hA55A);
        check("post_rst_perr", protocol_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter I_ADDR_W, default 12, instruction address width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, instruction memory data width in bits; instructions are 2*DATA_W bits (two bytes).
REQ-003 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have pc  input  I_ADDR_W  current program counter value.
REQ-006 SHALL have halt  input  1  when high, no new instruction fetch is started.
REQ-007 SHALL have imem_req  output  1  byte read request to instruction memory.
REQ-008 SHALL have imem_addr  output  I_ADDR_W  byte address of the request.
REQ-009 SHALL have imem_ready  input  1  memory accepts the request in any cycle where imem_req && imem_ready.
REQ-010 SHALL have imem_rvalid  input  1  read data valid; never earlier than the cycle after acceptance.
REQ-011 SHALL have imem_rdata  input  DATA_W  read data, sampled when imem_rvalid is high.
REQ-012 SHALL have inst  output  2*DATA_W  assembled instruction.
REQ-013 SHALL have inst_valid  output  1  inst holds a complete instruction.
REQ-014 SHALL have inst_ready  input  1  decode accepts inst in any cycle where inst_valid && inst_ready.
REQ-015 SHALL have pc_en  output  1  one-cycle pulse commanding the program counter to load its next value.
REQ-016 SHALL have busy  output  1  high in every state except IDLE.
REQ-017 SHALL have protocol_err  output  1  sticky flag for an unexpected imem_rvalid.

Function
REQ-018 SHALL implement states IDLE, REQ0, WAIT0, REQ1, WAIT1, HOLD.
REQ-019 IDLE: SHALL go to REQ0 when halt is low, else remain in IDLE.
REQ-020 REQ0: imem_req=1, imem_addr=pc; SHALL go to WAIT0 on acceptance, else remain with imem_addr unchanged.
REQ-021 WAIT0: on imem_rvalid SHALL capture imem_rdata into inst[DATA_W-1:0] and go to REQ1.
REQ-022 REQ1: imem_req=1, imem_addr=pc+1 truncated to I_ADDR_W bits (wraps 0xFFF->0x000); SHALL go to WAIT1 on acceptance.
REQ-023 WAIT1: on imem_rvalid SHALL capture imem_rdata into inst[2*DATA_W-1:DATA_W] and go to HOLD.
REQ-024 HOLD: inst_valid=1; inst SHALL remain stable until accepted.
REQ-025 On acceptance in HOLD, pc_en SHALL be 1 in that same cycle only; next state REQ0 if halt is low, else IDLE.
REQ-026 pc_en SHALL be 0 in every other cycle; imem_req SHALL be 0 outside REQ0/REQ1; inst_valid SHALL be 0 outside HOLD.
REQ-027 halt asserted mid-fetch SHALL NOT abort the fetch; the instruction completes to HOLD and is delivered normally.
REQ-028 imem_rvalid in any state other than WAIT0/WAIT1 SHALL be ignored as data and SHALL set protocol_err, which remains set until reset.
REQ-029 Minimum latency with imem_ready=1 and imem_rvalid one cycle after acceptance: inst_valid SHALL rise 4 cycles after leaving IDLE (REQ0,WAIT0,REQ1,WAIT1,HOLD); back-to-back throughput is one instruction per 5 cycles.

Reset
REQ-030 While rst_n is low, state SHALL be IDLE, and inst, inst_valid, imem_req, imem_addr, pc_en, busy and protocol_err SHALL be 0.
REQ-031 Reset asserted mid-fetch SHALL discard partial instruction bytes; the first fetch after release re-reads from pc.

Verification
REQ-032 pc=0x010, halt=0, imem_ready=1, rvalid one cycle after acceptance, bytes 0x34,0x12 -> imem_addr 0x010 then 0x011, inst=0x1234, inst_valid 4 cycles after leaving IDLE.
REQ-033 inst_ready=0 for 3 cycles in HOLD -> inst stable, pc_en=0; inst_ready=1 -> single pc_en pulse, REQ0 next cycle with new pc.
REQ-034 pc=0xFFF -> second request imem_addr=0x000.
REQ-035 imem_ready=0 for 2 cycles in REQ0 -> imem_req held, imem_addr stable; proceeds on ready.
REQ-036 halt=1 asserted in WAIT0 -> instruction completes to HOLD; after acceptance state IDLE, busy=0, no imem_req.
REQ-037 imem_rvalid pulsed in IDLE -> protocol_err=1 and sticky; rst_n low in WAIT1 -> all outputs 0 and state IDLE immediately.
